// File: rtl/approx_mul_err_accum.sv
// Error-statistics accumulator for an approximate WxW multiplier; APPROX_ERR_MSE_EN adds sum_sq_err.
// Latency: 3 edges from accept to visible stats; 1 sample/cycle.
// Backpressure: in_ready only in RUN, dropping once N_SAMPLES are accepted.
module approx_mul_err_accum #(
  parameter int W         = 8,
  parameter int N_SAMPLES = 65536,
  parameter int ACC_W     = 32,
  parameter int CNT_W     = 17,
  parameter int SQ_W      = 48
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [2*W-1:0]     in_p,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic [2*W-1:0]     max_abs_err,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   sample_count,
  output logic               overflow
`ifdef APPROX_ERR_MSE_EN
  ,
  output logic [SQ_W-1:0]    sum_sq_err
`endif
);

  localparam int PW = 2 * W;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] acc_cnt_inc;
  logic             accept, start_ok;

  logic             s1_vld_q;
  logic [W-1:0]     s1_a_q, s1_b_q;
  logic [PW-1:0]    s1_p_q;

  logic [PW-1:0]    exact;
  logic [PW:0]      diff;
  logic [PW-1:0]    err_c;

  logic             s2_vld_q, s2_nz_q;
  logic [PW-1:0]    s2_err_q;

  logic [ACC_W-1:0] sum_q, sum_d;
  logic [PW-1:0]    max_q, max_d;
  logic [CNT_W-1:0] errc_q, errc_d, samp_q, samp_d;
  logic             ovf_q, ovf_d;
  logic [SW-1:0]    sum_ext;
  logic [CNT_W:0]   errc_ext, samp_ext;

  assign in_ready    = (state_q == RUN);
  assign accept      = in_valid & in_ready;
  assign start_ok    = start & ((state_q == IDLE) | (state_q == DONE));
  assign acc_cnt_inc = acc_cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d   = RUN;
          acc_cnt_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_inc;
          if (acc_cnt_inc == CNT_W'(N_SAMPLES)) state_d = DRAIN;
        end
      end
      // Stage 1 empty means stage 2 retires on this edge, so stats and done land together.
      DRAIN: begin
        if (!s1_vld_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign exact = PW'(s1_a_q) * PW'(s1_b_q);
  assign diff  = {1'b0, exact} - {1'b0, s1_p_q};
  assign err_c = diff[PW] ? PW'(-diff) : diff[PW-1:0];

`ifdef APPROX_ERR_MSE_EN
  localparam int QW  = 4 * W;
  localparam int QSW = ((SQ_W > QW) ? SQ_W : QW) + 1;
  logic [QW-1:0]   s2_sq_q;
  logic [SQ_W-1:0] sq_q, sq_d;
  logic [QSW-1:0]  sq_ext;
  logic            sq_sat;
  assign sq_ext     = QSW'(sq_q) + QSW'(s2_sq_q);
  assign sq_sat     = |sq_ext[QSW-1:SQ_W];
  assign sum_sq_err = sq_q;
`else
  logic sq_sat;
  assign sq_sat = 1'b0;
`endif

  assign sum_ext  = SW'(sum_q) + SW'(s2_err_q);
  assign errc_ext = {1'b0, errc_q} + {{CNT_W{1'b0}}, s2_nz_q};
  assign samp_ext = {1'b0, samp_q} + (CNT_W + 1)'(1);

  always_comb begin
    sum_d  = sum_q;
    max_d  = max_q;
    errc_d = errc_q;
    samp_d = samp_q;
    ovf_d  = ovf_q;
`ifdef APPROX_ERR_MSE_EN
    sq_d   = sq_q;
`endif
    if (start_ok) begin
      sum_d  = '0;
      max_d  = '0;
      errc_d = '0;
      samp_d = '0;
      ovf_d  = 1'b0;
`ifdef APPROX_ERR_MSE_EN
      sq_d   = '0;
`endif
    end else if (s2_vld_q) begin
      sum_d  = (|sum_ext[SW-1:ACC_W]) ? '1 : sum_ext[ACC_W-1:0];
      max_d  = (s2_err_q > max_q) ? s2_err_q : max_q;
      errc_d = errc_ext[CNT_W] ? '1 : errc_ext[CNT_W-1:0];
      samp_d = samp_ext[CNT_W] ? '1 : samp_ext[CNT_W-1:0];
      ovf_d  = ovf_q | (|sum_ext[SW-1:ACC_W]) | errc_ext[CNT_W] | samp_ext[CNT_W] | sq_sat;
`ifdef APPROX_ERR_MSE_EN
      sq_d   = sq_sat ? '1 : sq_ext[SQ_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_p_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_err_q  <= '0;
      s2_nz_q   <= 1'b0;
      sum_q     <= '0;
      max_q     <= '0;
      errc_q    <= '0;
      samp_q    <= '0;
      ovf_q     <= 1'b0;
`ifdef APPROX_ERR_MSE_EN
      s2_sq_q   <= '0;
      sq_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      s1_vld_q  <= accept;
      if (accept) begin
        s1_a_q <= in_a;
        s1_b_q <= in_b;
        s1_p_q <= in_p;
      end
      s2_vld_q  <= s1_vld_q;
      if (s1_vld_q) begin
        s2_err_q <= err_c;
        s2_nz_q  <= |err_c;
`ifdef APPROX_ERR_MSE_EN
        s2_sq_q  <= QW'(err_c) * QW'(err_c);
`endif
      end
      sum_q     <= sum_d;
      max_q     <= max_d;
      errc_q    <= errc_d;
      samp_q    <= samp_d;
      ovf_q     <= ovf_d;
`ifdef APPROX_ERR_MSE_EN
      sq_q      <= sq_d;
`endif
    end
  end

  assign busy         = (state_q == RUN) | (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign sum_abs_err  = sum_q;
  assign max_abs_err  = max_q;
  assign err_count    = errc_q;
  assign sample_count = samp_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_approx_mul_err_accum.sv
// Directed bench: four instances (N=4, N=3, ACC_W=4/N=2, exhaustive N=65536) share one input bus.
module tb_approx_mul_err_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic [15:0] in_p = '0;
  logic [3:0]  start_v = '0;
  logic [3:0]  rdy_v, busy_v, done_v, ovf_v;
  int          errors = 0;
  int          checks = 0;
  int          sel = 0;

  logic [31:0] s0_sum, s1_sum, s3_sum;
  logic [3:0]  s2_sum;
  logic [15:0] s0_max, s1_max, s2_max, s3_max;
  logic [16:0] s0_errc, s1_errc, s2_errc, s3_errc;
  logic [16:0] s0_samp, s1_samp, s2_samp, s3_samp;
`ifdef APPROX_ERR_MSE_EN
  logic [47:0] s0_sq, s1_sq, s2_sq, s3_sq;
`endif

  always #5 clk = ~clk;

  approx_mul_err_accum #(.N_SAMPLES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy_v[0]),
    .in_a(in_a), .in_b(in_b), .in_p(in_p), .busy(busy_v[0]), .done(done_v[0]),
    .sum_abs_err(s0_sum), .max_abs_err(s0_max), .err_count(s0_errc), .sample_count(s0_samp),
    .overflow(ovf_v[0])
`ifdef APPROX_ERR_MSE_EN
    , .sum_sq_err(s0_sq)
`endif
  );

  approx_mul_err_accum #(.N_SAMPLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy_v[1]),
    .in_a(in_a), .in_b(in_b), .in_p(in_p), .busy(busy_v[1]), .done(done_v[1]),
    .sum_abs_err(s1_sum), .max_abs_err(s1_max), .err_count(s1_errc), .sample_count(s1_samp),
    .overflow(ovf_v[1])
`ifdef APPROX_ERR_MSE_EN
    , .sum_sq_err(s1_sq)
`endif
  );

  approx_mul_err_accum #(.N_SAMPLES(2), .ACC_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy_v[2]),
    .in_a(in_a), .in_b(in_b), .in_p(in_p), .busy(busy_v[2]), .done(done_v[2]),
    .sum_abs_err(s2_sum), .max_abs_err(s2_max), .err_count(s2_errc), .sample_count(s2_samp),
    .overflow(ovf_v[2])
`ifdef APPROX_ERR_MSE_EN
    , .sum_sq_err(s2_sq)
`endif
  );

  approx_mul_err_accum dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .in_valid(in_valid), .in_ready(rdy_v[3]),
    .in_a(in_a), .in_b(in_b), .in_p(in_p), .busy(busy_v[3]), .done(done_v[3]),
    .sum_abs_err(s3_sum), .max_abs_err(s3_max), .err_count(s3_errc), .sample_count(s3_samp),
    .overflow(ovf_v[3])
`ifdef APPROX_ERR_MSE_EN
    , .sum_sq_err(s3_sq)
`endif
  );

  task automatic pulse_start();
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    in_valid = 1'b1; in_a = a; in_b = b; in_p = p;
    checks++;
    if (rdy_v[sel] !== 1'b1) begin
      errors++; $display("FAIL drive_ready inst=%0d got=%b want=1", sel, rdy_v[sel]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_v[sel] === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (done_v[sel] !== 1'b1) begin
      errors++; $display("FAIL wait_done inst=%0d got=%b want=1 (timeout)", sel, done_v[sel]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({s0_sum, s0_max, s0_errc, s0_samp, ovf_v[0]} !== '0) begin
      errors++; $display("FAIL reset_stats0 got=%h want=0", {s0_sum, s0_max, s0_errc, s0_samp});
    end
    checks++;
    if ({rdy_v, busy_v, done_v, ovf_v} !== 16'h0) begin
      errors++; $display("FAIL reset_ctrl got=%h want=0", {rdy_v, busy_v, done_v, ovf_v});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact_run();
    sel = 0;
    pulse_start();
    checks++;
    if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL t1_busy got=%b want=1", busy_v[0]); end
    drive(8'd1, 8'd2, 16'd2);
    drive(8'd7, 8'd9, 16'd63);
    drive(8'd255, 8'd255, 16'd65025);
    drive(8'd0, 8'd13, 16'd0);
    wait_done(10);
    checks++;
    if ({s0_sum, s0_max, s0_errc} !== '0) begin
      errors++; $display("FAIL t1_err_stats got=%0d/%0d/%0d want=0/0/0", s0_sum, s0_max, s0_errc);
    end
    checks++;
    if (s0_samp !== 17'd4) begin errors++; $display("FAIL t1_samples got=%0d want=4", s0_samp); end
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL t1_busy_done got=%b want=0", busy_v[0]); end
  endtask

  task automatic test_back_to_back();
    sel = 1;
    pulse_start();
    drive(8'd3, 8'd5, 16'd14);
    drive(8'd0, 8'd0, 16'd7);
    drive(8'd255, 8'd255, 16'd65025);
    checks++;
    if (rdy_v[1] !== 1'b0) begin errors++; $display("FAIL t2_ready_drop got=%b want=0", rdy_v[1]); end
    @(negedge clk);
    checks++;
    if (done_v[1] !== 1'b0) begin errors++; $display("FAIL t2_done_early got=%b want=0", done_v[1]); end
    @(negedge clk);
    checks++;
    if (done_v[1] !== 1'b1) begin errors++; $display("FAIL t2_done_latency got=%b want=1", done_v[1]); end
    checks++;
    if (s1_sum !== 32'd8) begin errors++; $display("FAIL t2_sum got=%0d want=8", s1_sum); end
    checks++;
    if (s1_max !== 16'd7) begin errors++; $display("FAIL t2_max got=%0d want=7", s1_max); end
    checks++;
    if (s1_errc !== 17'd2) begin errors++; $display("FAIL t2_errc got=%0d want=2", s1_errc); end
    checks++;
    if (s1_samp !== 17'd3) begin errors++; $display("FAIL t2_samples got=%0d want=3", s1_samp); end
`ifdef APPROX_ERR_MSE_EN
    checks++;
    if (s1_sq !== 48'd50) begin errors++; $display("FAIL t2_sq got=%0d want=50", s1_sq); end
`endif
  endtask

  task automatic test_gaps_and_restart();
    sel = 1;
    pulse_start();
    checks++;
    if ({s1_sum, s1_max, s1_errc, s1_samp} !== '0 || busy_v[1] !== 1'b1 || done_v[1] !== 1'b0) begin
      errors++; $display("FAIL t3_restart_clear got sum=%0d samp=%0d busy=%b done=%b want 0/0/1/0",
                         s1_sum, s1_samp, busy_v[1], done_v[1]);
    end
    drive(8'd3, 8'd5, 16'd14);
    repeat (5) @(negedge clk);
    drive(8'd0, 8'd0, 16'd7);
    repeat (5) @(negedge clk);
    drive(8'd255, 8'd255, 16'd65025);
    checks++;
    if (rdy_v[1] !== 1'b0) begin errors++; $display("FAIL t3_ready_drop got=%b want=0", rdy_v[1]); end
    wait_done(10);
    checks++;
    if ({s1_sum, s1_max, s1_errc, s1_samp} !== {32'd8, 16'd7, 17'd2, 17'd3}) begin
      errors++; $display("FAIL t3_stats got=%0d/%0d/%0d/%0d want=8/7/2/3", s1_sum, s1_max, s1_errc, s1_samp);
    end
  endtask

  task automatic test_saturation();
    sel = 2;
    pulse_start();
    drive(8'd2, 8'd5, 16'd0);
    drive(8'd1, 8'd1, 16'd11);
    wait_done(10);
    checks++;
    if (s2_sum !== 4'd15) begin errors++; $display("FAIL t4_sum_sat got=%0d want=15", s2_sum); end
    checks++;
    if (ovf_v[2] !== 1'b1) begin errors++; $display("FAIL t4_overflow got=%b want=1", ovf_v[2]); end
    checks++;
    if ({s2_max, s2_errc, s2_samp} !== {16'd10, 17'd2, 17'd2}) begin
      errors++; $display("FAIL t4_other got=%0d/%0d/%0d want=10/2/2", s2_max, s2_errc, s2_samp);
    end
  endtask

  task automatic test_midrun_reset();
    sel = 0;
    pulse_start();
    drive(8'd2, 8'd3, 16'd0);
    drive(8'd4, 8'd4, 16'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s0_sum, s0_max, s0_errc, s0_samp, ovf_v[0], busy_v[0], done_v[0], rdy_v[0]} !== '0) begin
      errors++; $display("FAIL t5_reset_outputs got sum=%0d samp=%0d busy=%b", s0_sum, s0_samp, busy_v[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_v[0], done_v[0], rdy_v[0]} !== 3'b000) begin
      errors++; $display("FAIL t5_idle got=%b want=000", {busy_v[0], done_v[0], rdy_v[0]});
    end
    pulse_start();
    drive(8'd2, 8'd3, 16'd4);
    drive(8'd4, 8'd4, 16'd20);
    drive(8'd10, 8'd10, 16'd100);
    drive(8'd1, 8'd1, 16'd0);
    wait_done(10);
    checks++;
    if ({s0_sum, s0_max, s0_errc, s0_samp} !== {32'd7, 16'd4, 17'd3, 17'd4}) begin
      errors++; $display("FAIL t5_fresh_run got=%0d/%0d/%0d/%0d want=7/4/3/4", s0_sum, s0_max, s0_errc, s0_samp);
    end
`ifdef APPROX_ERR_MSE_EN
    checks++;
    if (s0_sq !== 48'd21) begin errors++; $display("FAIL t5_sq got=%0d want=21", s0_sq); end
`endif
  endtask

  task automatic test_start_in_run();
    sel = 0;
    pulse_start();
    drive(8'd3, 8'd3, 16'd8);
    drive(8'd5, 8'd5, 16'd25);
    pulse_start();
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1 || s0_samp !== 17'd2 || s0_sum !== 32'd1) begin
      errors++; $display("FAIL t6_start_ignored got busy=%b samp=%0d sum=%0d want 1/2/1", busy_v[0], s0_samp, s0_sum);
    end
    drive(8'd6, 8'd7, 16'd40);
    drive(8'd8, 8'd8, 16'd64);
    wait_done(10);
    checks++;
    if ({s0_sum, s0_max, s0_errc, s0_samp} !== {32'd3, 16'd2, 17'd2, 17'd4}) begin
      errors++; $display("FAIL t6_stats got=%0d/%0d/%0d/%0d want=3/2/2/4", s0_sum, s0_max, s0_errc, s0_samp);
    end
  endtask

  task automatic test_exhaustive();
    logic [15:0] prod, p, e;
    logic [31:0] exp_sum;
    logic [15:0] exp_max;
    logic [16:0] exp_errc;
    logic [47:0] exp_sq;
    exp_sum = '0; exp_max = '0; exp_errc = '0; exp_sq = '0;
    sel = 3;
    pulse_start();
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        prod = 16'(a * b);
        p    = (prod & 16'hFFFC) | {15'd0, prod[15]};
        e    = (prod > p) ? prod - p : p - prod;
        exp_sum  = exp_sum + 32'(e);
        exp_max  = (e > exp_max) ? e : exp_max;
        exp_errc = exp_errc + ((e != 0) ? 17'd1 : 17'd0);
        exp_sq   = exp_sq + 48'(e) * 48'(e);
        drive(8'(a), 8'(b), p);
      end
    end
    wait_done(10);
    checks++;
    if (s3_sum !== exp_sum) begin errors++; $display("FAIL t7_sum got=%0d want=%0d", s3_sum, exp_sum); end
    checks++;
    if (s3_max !== exp_max) begin errors++; $display("FAIL t7_max got=%0d want=%0d", s3_max, exp_max); end
    checks++;
    if (s3_errc !== exp_errc) begin errors++; $display("FAIL t7_errc got=%0d want=%0d", s3_errc, exp_errc); end
    checks++;
    if (s3_samp !== 17'd65536 || ovf_v[3] !== 1'b0) begin
      errors++; $display("FAIL t7_samples got=%0d ovf=%b want=65536/0", s3_samp, ovf_v[3]);
    end
`ifdef APPROX_ERR_MSE_EN
    checks++;
    if (s3_sq !== exp_sq) begin errors++; $display("FAIL t7_sq got=%0d want=%0d", s3_sq, exp_sq); end
`endif
  endtask

  initial begin
    test_reset();
    test_exact_run();
    test_back_to_back();
    test_gaps_and_restart();
    test_saturation();
    test_midrun_reset();
    test_start_in_run();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
